// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the instruction loader slice.
//   ADDR_W / WORD_W : default instruction address and word widths.
//   IMEM_DEPTH      : number of instruction RAM words (2**ADDR_W).
//   checksum_t      : type of the load checksum (one instruction word wide).
//   loader_state_e  : loader FSM states, also exported on the debug port.
package loader_pkg;

    localparam int ADDR_W     = 8;
    localparam int WORD_W     = 9;
    localparam int IMEM_DEPTH = 2 ** ADDR_W;

    typedef logic [WORD_W-1:0] checksum_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clear      : synchronous clear, wins over en
//   en         : count one step this cycle
//   count      : current value, saturates at 2**WIDTH-1
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: writes a streamed program into instruction RAM, strobes the
// core's start input, waits for halt and reports run length and checksum.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load_req, load_len  : start a load of load_len words (1..2**A), IDLE/DONE only
//   in_valid/in_ready   : word stream handshake; a word moves on a clock edge
//                         where both are high. in_ready is a combinational
//                         function of state only, never of in_valid.
//   in_data             : instruction word being offered
//   imem_we/addr/wdata  : registered RAM write port, one cycle after transfer
//   cpu_start, cpu_halt : start strobe to / halt flag from the core
//   busy, done, err     : status (err is sticky until a good load_req)
//   checksum            : XOR of the words accepted in the current load
//   run_cycles          : cycles spent in RUN before halt, saturating
//   dbg_state           : current FSM state
module instr_loader
    import loader_pkg::*;
#(
    parameter int A            = ADDR_W,
    parameter int W            = WORD_W,
    parameter int START_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_req,
    input  logic [A:0]       load_len,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             imem_we,
    output logic [A-1:0]     imem_addr,
    output logic [W-1:0]     imem_wdata,
    output logic             cpu_start,
    input  logic             cpu_halt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     checksum,
    output logic [CNT_W-1:0] run_cycles,
    output loader_state_e    dbg_state
);

    localparam logic [A:0] DEPTH_L    = (A+1)'(2 ** A);
    localparam logic [3:0] START_LAST = 4'(START_CYCLES - 1);

    loader_state_e state;
    logic [A:0]    count;
    logic [A:0]    len_q;
    logic [3:0]    start_cnt;

    logic xfer;
    logic len_bad;
    logic load_accept;

    // count < len_q always holds in LOAD (the last word leaves LOAD), the
    // compare only guards against ever accepting past the latched length.
    assign in_ready    = (state == LOAD) && (count < len_q);
    assign xfer        = in_valid && in_ready;
    assign len_bad     = (load_len == '0) || (load_len > DEPTH_L);
    assign load_accept = ((state == IDLE) || (state == DONE)) && load_req && !len_bad;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            len_q      <= '0;
            start_cnt  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            checksum   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (xfer) begin
                imem_we    <= 1'b1;
                imem_addr  <= count[A-1:0];
                imem_wdata <= in_data;
                checksum   <= checksum ^ in_data;
                count      <= count + (A+1)'(1);
            end

            case (state)
                IDLE, DONE: begin
                    if (load_req) begin
                        done <= 1'b0;
                        if (len_bad) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            err      <= 1'b0;
                            checksum <= '0;
                            count    <= '0;
                            len_q    <= load_len;
                            busy     <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (xfer && (count == len_q - (A+1)'(1))) begin
                        cpu_start <= 1'b1;
                        start_cnt <= START_LAST;
                        state     <= START;
                    end
                end
                START: begin
                    // cpu_halt is deliberately not looked at here: the core
                    // may still be showing halt from the previous program.
                    if (start_cnt == 4'd0) begin
                        cpu_start <= 1'b0;
                        state     <= RUN;
                    end else begin
                        start_cnt <= start_cnt - 4'd1;
                    end
                end
                RUN: begin
                    if (cpu_halt) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The halt cycle itself is not counted, so halt on the first RUN cycle
    // leaves run_cycles at 0.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (load_accept),
        .en    ((state == RUN) && !cpu_halt),
        .count (run_cycles)
    );

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized self-checking bench for instr_loader. A second
// instance built with CNT_W=4 shares all inputs to observe run_cycles
// saturation. Expected RAM writes come from a queue filled by the driver.
module tb_instr_loader;
    import loader_pkg::*;

    localparam int A     = 8;
    localparam int W     = 9;
    localparam int CNT_W = 16;
    localparam int SC    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_req;
    logic [A:0]       load_len;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             cpu_halt;

    logic             in_ready, imem_we, cpu_start, busy, done, err;
    logic [A-1:0]     imem_addr;
    logic [W-1:0]     imem_wdata, checksum;
    logic [CNT_W-1:0] run_cycles;
    loader_state_e    dbg_state;

    logic             s_in_ready, s_imem_we, s_cpu_start, s_busy, s_done, s_err;
    logic [A-1:0]     s_imem_addr;
    logic [W-1:0]     s_imem_wdata, s_checksum;
    logic [3:0]       s_run_cycles;
    loader_state_e    s_dbg_state;

    int               n_vec = 0;
    int               n_err = 0;
    logic [A+W-1:0]   exp_q[$];
    checksum_t        model_sum;
    int               next_addr;
    logic [W-1:0]     prog[0:IMEM_DEPTH-1];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    instr_loader #(.A(A), .W(W), .START_CYCLES(SC), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_start(cpu_start), .cpu_halt(cpu_halt), .busy(busy), .done(done),
        .err(err), .checksum(checksum), .run_cycles(run_cycles), .dbg_state(dbg_state)
    );

    instr_loader #(.A(A), .W(W), .START_CYCLES(SC), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .cpu_start(s_cpu_start), .cpu_halt(cpu_halt), .busy(s_busy), .done(s_done),
        .err(s_err), .checksum(s_checksum), .run_cycles(s_run_cycles), .dbg_state(s_dbg_state)
    );

    // ---------------- scoreboard: RAM write port ----------------
    always @(negedge clk) begin
        logic [A+W-1:0] exp_w;
        if (imem_we === 1'b1) begin
            n_vec++;
            if (rst_n !== 1'b1 || exp_q.size() == 0) begin
                n_err++;
                $display("FAIL imem_write_unexpected: got addr %h data %h, want no write", imem_addr, imem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== exp_w) begin
                    n_err++;
                    $display("FAIL imem_write: got addr %h data %h, want addr %h data %h",
                             imem_addr, imem_wdata, exp_w[A+W-1:W], exp_w[W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(input int len);
        load_req = 1'b1;
        load_len = len[A:0];
        if (len >= 1 && len <= IMEM_DEPTH) begin
            model_sum = '0;
            next_addr = 0;
        end
        tick();
        load_req = 1'b0;
    endtask

    // mode 0: always valid, 1: random valid, 2: valid pattern 1,0,0,1
    task automatic send_words(input int n, input int mode);
        int  sent;
        int  slot;
        int  budget;
        logic v;
        sent   = 0;
        slot   = 0;
        budget = n * 8 + 20;
        while (sent < n && budget > 0) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = ((slot % 4) == 0) || ((slot % 4) == 3);
            endcase
            in_valid = v;
            in_data  = v ? prog[sent] : W'($urandom);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL in_ready_load: got %b want 1 (word %0d)", in_ready, sent);
            end
            if (v && in_ready === 1'b1) begin
                exp_q.push_back({next_addr[A-1:0], prog[sent]});
                model_sum ^= prog[sent];
                next_addr++;
                sent++;
            end
            tick();
            slot++;
            budget--;
        end
        in_valid = 1'b0;
        n_vec++;
        if (sent != n) begin
            n_err++;
            $display("FAIL load_timeout: got %0d words accepted, want %0d", sent, n);
        end
    endtask

    // Entered in the first START cycle (right after the last transfer edge).
    task automatic check_start_run(input int n_halt, input bit stale, input bit poke);
        int hi;
        int exp4;
        n_vec++;
        if (imem_we !== 1'b1 || cpu_start !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL last_write_start: got we %b start %b ready %b, want 1 1 0", imem_we, cpu_start, in_ready);
        end
        hi = 0;
        while (cpu_start === 1'b1 && hi < 20) begin
            hi++;
            tick();
        end
        n_vec++;
        if (hi != SC) begin
            n_err++;
            $display("FAIL start_len: got %0d cycles, want %0d", hi, SC);
        end
        n_vec++;
        if (dbg_state !== RUN || busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL run_entry: got state %0d busy %b done %b, want %0d 1 0", dbg_state, busy, done, RUN);
        end
        for (int k = 0; k < n_halt; k++) begin
            load_req = (poke && k == 0);
            load_len = 9'd5;
            if (k > 0) begin
                n_vec++;
                if (dbg_state !== RUN || in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL run_hold: got state %0d ready %b, want %0d 0", dbg_state, in_ready, RUN);
                end
            end
            tick();
        end
        load_req = 1'b0;
        if (!stale) cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        exp4 = (n_halt > 15) ? 15 : n_halt;
        n_vec++;
        if (dbg_state !== DONE || done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_state: got state %0d done %b busy %b, want %0d 1 0", dbg_state, done, busy, DONE);
        end
        n_vec++;
        if (run_cycles !== n_halt[CNT_W-1:0]) begin
            n_err++;
            $display("FAIL run_cycles: got %0d want %0d", run_cycles, n_halt);
        end
        n_vec++;
        if (s_run_cycles !== exp4[3:0]) begin
            n_err++;
            $display("FAIL run_cycles_sat: got %0d want %0d", s_run_cycles, exp4);
        end
        n_vec++;
        if (checksum !== model_sum) begin
            n_err++;
            $display("FAIL checksum: got %h want %h", checksum, model_sum);
        end
        repeat (3) tick();
        n_vec++;
        if (done !== 1'b1 || checksum !== model_sum || run_cycles !== n_halt[CNT_W-1:0]) begin
            n_err++;
            $display("FAIL done_hold: got done %b sum %h cyc %0d, want 1 %h %0d", done, checksum, run_cycles, model_sum, n_halt);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL writes_missing: got %0d pending, want 0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        load_req = 1'b0;
        load_len = '0;
        in_valid = 1'b0;
        in_data  = '0;
        cpu_halt = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_start, busy, done, err, checksum, run_cycles} !== '0
            || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_outputs: got ready %b we %b start %b busy %b done %b err %b sum %h cyc %0d state %0d, want all 0",
                     in_ready, imem_we, cpu_start, busy, done, err, checksum, run_cycles, dbg_state);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        prog[0] = 9'h1A5;
        prog[1] = 9'h0F0;
        prog[2] = 9'h100;
        issue_load(3);
        send_words(3, 0);
        n_vec++;
        if (checksum !== 9'h055) begin
            n_err++;
            $display("FAIL basic_checksum: got %h want 055", checksum);
        end
        check_start_run(10, 1'b0, 1'b0);
    endtask

    task automatic test_gapped();
        prog[0] = W'($urandom);
        prog[1] = W'($urandom);
        issue_load(2);
        send_words(2, 2);
        check_start_run($urandom_range(0, 5), 1'b0, 1'b0);
    endtask

    task automatic test_bad_len();
        int bad[2];
        bad[0] = 0;
        bad[1] = 257;
        foreach (bad[i]) begin
            issue_load(bad[i]);
            in_valid = 1'b1;
            in_data  = W'($urandom);
            n_vec++;
            if (err !== 1'b1 || dbg_state !== IDLE || in_ready !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL bad_len_%0d: got err %b state %0d ready %b done %b, want 1 %0d 0 0",
                         bad[i], err, dbg_state, in_ready, done, IDLE);
            end
            tick();
            in_valid = 1'b0;
        end
        prog[0] = W'($urandom);
        issue_load(1);
        n_vec++;
        if (err !== 1'b0 || dbg_state !== LOAD) begin
            n_err++;
            $display("FAIL bad_len_clear: got err %b state %0d, want 0 %0d", err, dbg_state, LOAD);
        end
        send_words(1, 0);
        check_start_run(3, 1'b0, 1'b1);
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < IMEM_DEPTH; i++) prog[i] = W'(i);
        issue_load(IMEM_DEPTH);
        send_words(IMEM_DEPTH, 0);
        n_vec++;
        if (checksum !== 9'h000) begin
            n_err++;
            $display("FAIL full_checksum: got %h want 000", checksum);
        end
        check_start_run(20, 1'b0, 1'b0);
    endtask

    task automatic test_stale_halt();
        for (int i = 0; i < 4; i++) prog[i] = W'($urandom);
        cpu_halt = 1'b1;
        issue_load(4);
        send_words(4, 1);
        check_start_run(0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int len;
        int nh;
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 24);
            nh  = $urandom_range(0, 25);
            for (int i = 0; i < len; i++) prog[i] = W'($urandom);
            issue_load(len);
            send_words(len, 1);
            check_start_run(nh, 1'b0, (nh >= 2) && ($urandom_range(0, 1) == 1));
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) prog[i] = W'($urandom);
        issue_load(5);
        send_words(2, 0);
        // second write is on the port right now; reset must kill it
        in_valid = 1'b1;
        in_data  = W'($urandom);
        rst_n    = 1'b0;
        #1;
        exp_q.delete();
        n_vec++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_start, busy, done, err, checksum, run_cycles} !== '0
            || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got ready %b we %b busy %b sum %h state %0d, want all 0",
                     in_ready, imem_we, busy, checksum, dbg_state);
        end
        repeat (3) tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) prog[i] = W'($urandom);
        issue_load(3);
        send_words(3, 1);
        check_start_run(5, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_bad_len();
        test_full_depth();
        test_stale_halt();
        test_random();
        test_reset_mid();
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
